// File: rtl/sclk_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sclk_gen_pkg
//  Purpose  : Shared types for the SPI clock generator (FSM state, SPI mode).
//  Revision : 1.0 - initial release
// ============================================================================
package sclk_gen_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sclk_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Leading edges sample when cpha=0, trailing edges sample when cpha=1.
    function automatic logic strobe_is_sample(input logic cpha, input logic trailing);
        return (cpha == trailing);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sclk_halfper_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : sclk_halfper_cnt
//  Purpose  : Half-period down-counter; tick marks the last clk_in cycle of
//             each SCLK half-period (a half_period of 0 behaves as 1).
//  Revision : 1.0 - initial release
// ============================================================================
module sclk_halfper_cnt #(
    parameter int DIV_W = 16
) (
    input  logic             clk_in,
    input  logic             sresetn,
    input  logic             load,
    input  logic [DIV_W-1:0] half_period,
    input  logic             run,
    output logic             tick
);

    localparam logic [DIV_W-1:0] c_ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_reload;
    logic [DIV_W-1:0] w_reload;

    assign w_reload = (half_period == '0) ? '0 : (half_period - c_ONE);
    assign tick     = run && (r_cnt == '0);

    always_ff @(posedge clk_in) begin
        if (!sresetn) begin
            r_cnt    <= '0;
            r_reload <= '0;
        end else if (load) begin
            r_cnt    <= w_reload;
            r_reload <= w_reload;
        end else if (run) begin
            if (r_cnt == '0) begin
                r_cnt <= r_reload;
            end else begin
                r_cnt <= r_cnt - c_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : sclk_gen
//  Purpose  : SPI SCLK burst generator with sample/shift strobes.
//             Optional abort input enabled by defining SCLK_GEN_ABORT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module sclk_gen
    import sclk_gen_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int CNT_W = 6
) (
    input  logic             clk_in,
    input  logic             sresetn,
    input  logic             start,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [DIV_W-1:0] half_period,
    input  logic [CNT_W-1:0] num_bits,
`ifdef SCLK_GEN_ABORT_EN
    input  logic             abort,
`endif
    output logic             sclk,
    output logic             strobe_sample,
    output logic             strobe_shift,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W:0] c_EDGE_ONE = (CNT_W+1)'(1);

    sclk_state_t      r_state;
    sclk_state_t      w_state_next;
    spi_mode_t        r_mode;
    logic [CNT_W-1:0] r_num_bits;
    logic [CNT_W:0]   r_edge_cnt;
    logic             r_sclk;
    logic             r_done;

    logic w_abort;
    logic w_accept;
    logic w_run;
    logic w_tick;
    logic w_last;
    logic w_trailing;
    logic w_smp;
    logic w_shf;

`ifdef SCLK_GEN_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_run      = (r_state == RUN);
    // A start coinciding with the done pulse is deliberately dropped.
    assign w_accept   = (r_state == IDLE) && start && (num_bits != '0) && !r_done && !w_abort;
    assign w_trailing = r_edge_cnt[0];
    assign w_last     = w_tick && (r_edge_cnt == ({r_num_bits, 1'b0} - c_EDGE_ONE));

    sclk_halfper_cnt #(
        .DIV_W(DIV_W)
    ) u_halfper_cnt (
        .clk_in     (clk_in),
        .sresetn    (sresetn),
        .load       (w_accept),
        .half_period(half_period),
        .run        (w_run),
        .tick       (w_tick)
    );

    always_ff @(posedge clk_in) begin
        if (!sresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == IDLE) begin
            if (w_accept) begin
                w_state_next = RUN;
            end
        end else begin
            if (w_abort || w_last) begin
                w_state_next = IDLE;
            end
        end
    end

    always_comb begin
        w_smp = 1'b0;
        w_shf = 1'b0;
        if (sresetn && w_run && w_tick && !w_abort) begin
            if (strobe_is_sample(r_mode.cpha, w_trailing)) begin
                w_smp = 1'b1;
            end else if (!(w_last && !r_mode.cpha)) begin
                w_shf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!sresetn) begin
            r_mode     <= '0;
            r_num_bits <= '0;
            r_edge_cnt <= '0;
            r_sclk     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                r_sclk     <= cpol;
                r_edge_cnt <= '0;
                if (w_accept) begin
                    r_mode     <= '{cpol: cpol, cpha: cpha};
                    r_num_bits <= num_bits;
                end
            end else if (w_abort) begin
                r_sclk     <= r_mode.cpol;
                r_edge_cnt <= '0;
            end else if (w_last) begin
                r_sclk     <= r_mode.cpol;
                r_edge_cnt <= '0;
                r_done     <= 1'b1;
            end else if (w_tick) begin
                r_sclk     <= ~r_sclk;
                r_edge_cnt <= r_edge_cnt + c_EDGE_ONE;
            end
        end
    end

    assign sclk          = r_sclk;
    assign busy          = w_run;
    assign done          = r_done;
    assign strobe_sample = w_smp;
    assign strobe_shift  = w_shf;

endmodule
`default_nettype wire

// File: tb/tb_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sclk_gen
//  Purpose  : Directed self-checking bench for sclk_gen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sclk_gen;

    logic        clk_in = 1'b0;
    logic        sresetn;
    logic        start;
    logic        cpol;
    logic        cpha;
    logic [15:0] half_period;
    logic [5:0]  num_bits;
`ifdef SCLK_GEN_ABORT_EN
    logic        abort;
`endif
    logic        sclk;
    logic        strobe_sample;
    logic        strobe_shift;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    // Burst statistics filled by run_burst
    int          n_busy, n_smp, n_shf, n_done, n_rise, n_fall;
    int          n_rise_smp, n_rise_shf, n_fall_smp, n_fall_shf;
    int          first_edge;
    logic        idle_sclk, end_sclk, done_seen;
    logic [31:0] wave;
    logic [31:0] wave_ref;

    always #5 clk_in = ~clk_in;

    sclk_gen #(
        .DIV_W(16),
        .CNT_W(6)
    ) dut (
        .clk_in       (clk_in),
        .sresetn      (sresetn),
        .start        (start),
        .cpol         (cpol),
        .cpha         (cpha),
        .half_period  (half_period),
        .num_bits     (num_bits),
`ifdef SCLK_GEN_ABORT_EN
        .abort        (abort),
`endif
        .sclk         (sclk),
        .strobe_sample(strobe_sample),
        .strobe_shift (strobe_shift),
        .busy         (busy),
        .done         (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Launches one burst and gathers statistics until done or the cycle limit.
    task automatic run_burst(input logic cp, input logic ch, input logic [15:0] hp,
                             input logic [5:0] nb, input bit mutate, input int limit);
        logic prev_sclk, prev_smp, prev_shf;
        n_busy = 0; n_smp = 0; n_shf = 0; n_done = 0; n_rise = 0; n_fall = 0;
        n_rise_smp = 0; n_rise_shf = 0; n_fall_smp = 0; n_fall_shf = 0;
        first_edge = -1; wave = '0; done_seen = 1'b0;
        cpol = cp; cpha = ch; half_period = hp; num_bits = nb;
        step();
        idle_sclk = sclk;
        start     = 1'b1;
        prev_sclk = sclk; prev_smp = strobe_sample; prev_shf = strobe_shift;
        for (int k = 1; k <= limit && !done_seen; k++) begin
            step();
            if (k == 1) start = 1'b0;
            if (mutate && k == 5) begin
                cpol = ~cp; half_period = hp + 16'd5; start = 1'b1;
            end
            if (mutate && k == 6) start = 1'b0;
            if (k < 32) wave[k] = sclk;
            n_busy += int'(busy);
            n_smp  += int'(strobe_sample);
            n_shf  += int'(strobe_shift);
            if (sclk !== prev_sclk) begin
                if (first_edge < 0) first_edge = k - 1;
                if (sclk) begin
                    n_rise++; n_rise_smp += int'(prev_smp); n_rise_shf += int'(prev_shf);
                end else begin
                    n_fall++; n_fall_smp += int'(prev_smp); n_fall_shf += int'(prev_shf);
                end
            end
            if (done) begin
                n_done++;
                done_seen = 1'b1;
            end
            prev_sclk = sclk; prev_smp = strobe_sample; prev_shf = strobe_shift;
        end
        end_sclk = sclk;
        check("burst_done_seen", done_seen, 1);
    endtask

    initial begin
        int edges;
        int cnt_busy, cnt_done;
        sresetn = 1'b0; start = 1'b0; cpol = 1'b1; cpha = 1'b0;
        half_period = 16'd2; num_bits = 6'd8;
`ifdef SCLK_GEN_ABORT_EN
        abort = 1'b0;
`endif
        // Reset state: sclk forced 0 even with cpol=1
        repeat (3) step();
        check("rst_sclk", sclk, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_strobes", {strobe_sample, strobe_shift}, 0);
        sresetn = 1'b1;
        step();
        check("rst_release_sclk_cpol", sclk, 1);

        // Mode 0, hp=2, nb=8
        run_burst(1'b0, 1'b0, 16'd2, 6'd8, 1'b0, 200);
        check("m0_idle_sclk", idle_sclk, 0);
        check("m0_busy_cycles", n_busy, 32);
        check("m0_rises", n_rise, 8);
        check("m0_rise_after_sample", n_rise_smp, 8);
        check("m0_samples", n_smp, 8);
        check("m0_shifts", n_shf, 7);
        check("m0_done", n_done, 1);
        check("m0_first_edge", first_edge, 2);
        check("m0_end_sclk", end_sclk, 0);

        // Mode 3, hp=1, nb=4
        run_burst(1'b1, 1'b1, 16'd1, 6'd4, 1'b0, 100);
        check("m3_idle_sclk", idle_sclk, 1);
        check("m3_falls", n_fall, 4);
        check("m3_fall_after_shift", n_fall_shf, 4);
        check("m3_shifts", n_shf, 4);
        check("m3_samples", n_smp, 4);
        check("m3_busy_cycles", n_busy, 8);
        check("m3_end_sclk", end_sclk, 1);

        // Mode 2, hp=3, nb=2: leading falls sample, final trailing shift suppressed
        run_burst(1'b1, 1'b0, 16'd3, 6'd2, 1'b0, 100);
        check("m2_busy_cycles", n_busy, 12);
        check("m2_fall_after_sample", n_fall_smp, 2);
        check("m2_samples", n_smp, 2);
        check("m2_shifts", n_shf, 1);
        check("m2_first_edge", first_edge, 3);

        // Mode 1, hp=1, nb=3: leading rises shift, trailing falls sample
        run_burst(1'b0, 1'b1, 16'd1, 6'd3, 1'b0, 100);
        check("m1_rise_after_shift", n_rise_shf, 3);
        check("m1_fall_after_sample", n_fall_smp, 3);
        wave_ref = wave;

        // hp=1 vs hp=0 on mode 0, nb=3: sclk 0,1,0,1,0,1,0 over samples 1..7
        run_burst(1'b0, 1'b0, 16'd1, 6'd3, 1'b0, 100);
        check("hp1_wave", wave, 32'h54);
        run_burst(1'b0, 1'b0, 16'd0, 6'd3, 1'b0, 100);
        check("hp0_wave", wave, 32'h54);
        check("hp0_busy_cycles", n_busy, 6);
        check("m1_wave_vs_m0", wave_ref, 32'h54);

        // num_bits=0: start ignored
        num_bits = 6'd0; cpol = 1'b0; start = 1'b1;
        cnt_busy = 0; cnt_done = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            start = 1'b0;
            cnt_busy += int'(busy);
            cnt_done += int'(done);
        end
        check("nb0_busy", cnt_busy, 0);
        check("nb0_done", cnt_done, 0);

        // Mid-burst cpol/half_period change and second start are ignored
        run_burst(1'b0, 1'b0, 16'd2, 6'd4, 1'b1, 200);
        check("mut_busy_cycles", n_busy, 16);
        check("mut_rises", n_rise, 4);
        check("mut_done", n_done, 1);
        check("mut_end_sclk_latched", end_sclk, 0);
        // start in the done cycle is dropped
        start = 1'b1;
        step();
        start = 1'b0;
        check("done_cycle_start_busy", busy, 0);
        step();
        check("done_cycle_start_busy2", busy, 0);

        // Reset at edge 3 of a mode-2 burst
        cpol = 1'b1; cpha = 1'b0; half_period = 16'd2; num_bits = 6'd4;
        step();
        start = 1'b1;
        edges = 0;
        begin
            logic ps;
            ps = sclk;
            for (int k = 0; k < 100 && edges < 3; k++) begin
                step();
                start = 1'b0;
                if (sclk !== ps) edges++;
                ps = sclk;
            end
        end
        check("rst_mid_edges", edges, 3);
        sresetn = 1'b0;
        step();
        check("rst_mid_sclk", sclk, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_strobes", {strobe_sample, strobe_shift}, 0);
        sresetn = 1'b1;
        step();
        check("rst_mid_release_sclk", sclk, 1);
        cnt_done = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            cnt_done += int'(done) + int'(busy);
        end
        check("rst_mid_no_done", cnt_done, 0);

`ifdef SCLK_GEN_ABORT_EN
        // Abort after edge 3 of a mode-0 burst
        cpol = 1'b0; cpha = 1'b0; half_period = 16'd2; num_bits = 6'd4;
        step();
        start = 1'b1;
        edges = 0;
        begin
            logic ps;
            ps = sclk;
            for (int k = 0; k < 100 && edges < 3; k++) begin
                step();
                start = 1'b0;
                if (sclk !== ps) edges++;
                ps = sclk;
            end
        end
        abort = 1'b1;
        #1;
        check("abort_no_strobe", {strobe_sample, strobe_shift}, 0);
        step();
        abort = 1'b0;
        check("abort_sclk", sclk, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        // abort beats a simultaneous start in IDLE
        abort = 1'b1; start = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        check("abort_vs_start_busy", busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
